// File: rtl/rv_decode_stage.sv
// RV32I decode stage: forwarding, load-use interlock, branch/jump redirect with one-beat drop.
// One cycle from accept to ex_valid_o; stalls fetch while the output is held or a load result is pending.
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [XLEN-1:0]   if_pc_i,
  input  logic [31:0]       if_inst_i,
  output logic [4:0]        rf_raddr1_o,
  output logic [4:0]        rf_raddr2_o,
  input  logic [XLEN-1:0]   rf_rdata1_i,
  input  logic [XLEN-1:0]   rf_rdata2_i,
  input  logic [NFWD-1:0]   fwd_we_i,
  input  logic [NFWD-1:0]   fwd_pend_i,
  input  logic [5*NFWD-1:0] fwd_rd_i,
  input  logic [XLEN*NFWD-1:0] fwd_data_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [7:0]        ex_aluop_o,
  output logic [2:0]        ex_alusel_o,
  output logic [XLEN-1:0]   ex_op1_o,
  output logic [XLEN-1:0]   ex_op2_o,
  output logic [4:0]        ex_rd_o,
  output logic              ex_wreg_o,
  output logic [XLEN-1:0]   ex_link_o,
  output logic              br_taken_o,
  output logic [XLEN-1:0]   br_target_o,
  output logic              illegal_o
);
  localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02, OP_SLL = 8'h03,
                         OP_SLT = 8'h04, OP_SLTU = 8'h05, OP_XOR = 8'h06, OP_SRL = 8'h07,
                         OP_SRA = 8'h08, OP_OR = 8'h09, OP_AND = 8'h0A;
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_ALU = 3'd1, SEL_JUMP = 3'd2, SEL_BRANCH = 3'd3;

  typedef enum logic [1:0] {S_RUN, S_STALL, S_DROP} state_t;
  state_t r_state;

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm_i, w_imm_u, w_imm_b, w_imm_j, w_shamt;

  assign w_opc = if_inst_i[6:0];
  assign w_f3  = if_inst_i[14:12];
  assign w_f7  = if_inst_i[31:25];
  assign w_rs1 = if_inst_i[19:15];
  assign w_rs2 = if_inst_i[24:20];
  assign rf_raddr1_o = w_rs1;
  assign rf_raddr2_o = w_rs2;

  assign w_imm_i = XLEN'($signed(if_inst_i[31:20]));
  assign w_imm_u = XLEN'($signed({if_inst_i[31:12], 12'b0}));
  assign w_imm_b = XLEN'($signed({if_inst_i[31], if_inst_i[7], if_inst_i[30:25], if_inst_i[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({if_inst_i[31], if_inst_i[19:12], if_inst_i[20], if_inst_i[30:21], 1'b0}));
  assign w_shamt = XLEN'(if_inst_i[24:20]);

  logic [XLEN-1:0] w_src1, w_src2;
  logic            w_pend1, w_pend2;

  // Descending scan so the lowest-index (youngest) matching port overrides older ones.
  always_comb begin
    w_src1  = rf_rdata1_i;
    w_src2  = rf_rdata2_i;
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_we_i[i] && fwd_rd_i[5*i +: 5] == w_rs1) begin
        w_src1  = fwd_data_i[XLEN*i +: XLEN];
        w_pend1 = fwd_pend_i[i];
      end
      if (fwd_we_i[i] && fwd_rd_i[5*i +: 5] == w_rs2) begin
        w_src2  = fwd_data_i[XLEN*i +: XLEN];
        w_pend2 = fwd_pend_i[i];
      end
    end
    if (w_rs1 == 5'd0) begin
      w_src1  = '0;
      w_pend1 = 1'b0;
    end
    if (w_rs2 == 5'd0) begin
      w_src2  = '0;
      w_pend2 = 1'b0;
    end
  end

  logic [7:0]      w_aluop;
  logic [2:0]      w_alusel;
  logic [XLEN-1:0] w_op1, w_op2, w_link, w_target;
  logic [4:0]      w_rd;
  logic            w_wr, w_use1, w_use2, w_ill, w_redir, w_cond;

  always_comb begin
    w_aluop  = OP_NOP;
    w_alusel = SEL_NOP;
    w_op1    = '0;
    w_op2    = '0;
    w_rd     = if_inst_i[11:7];
    w_wr     = 1'b0;
    w_link   = '0;
    w_target = '0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_ill    = 1'b0;
    w_redir  = 1'b0;
    w_cond   = 1'b0;
    case (w_opc)
      7'b0110111: begin
        w_aluop = OP_ADD; w_alusel = SEL_ALU; w_op2 = w_imm_u; w_wr = 1'b1;
      end
      7'b0010111: begin
        w_aluop = OP_ADD; w_alusel = SEL_ALU; w_op1 = if_pc_i; w_op2 = w_imm_u; w_wr = 1'b1;
      end
      7'b1101111: begin
        w_aluop = OP_ADD; w_alusel = SEL_JUMP; w_op1 = if_pc_i; w_op2 = XLEN'(4); w_wr = 1'b1;
        w_link = if_pc_i + XLEN'(4); w_redir = 1'b1; w_target = if_pc_i + w_imm_j;
      end
      7'b1100111: begin
        if (w_f3 != 3'b000) w_ill = 1'b1;
        w_use1 = 1'b1;
        w_aluop = OP_ADD; w_alusel = SEL_JUMP; w_op1 = if_pc_i; w_op2 = XLEN'(4); w_wr = 1'b1;
        w_link = if_pc_i + XLEN'(4); w_redir = 1'b1;
        w_target = (w_src1 + w_imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
      end
      7'b1100011: begin
        w_use1 = 1'b1; w_use2 = 1'b1;
        w_alusel = SEL_BRANCH; w_op1 = w_src1; w_op2 = w_src2; w_rd = 5'd0;
        w_target = if_pc_i + w_imm_b;
        case (w_f3)
          3'b000:  w_cond = (w_src1 == w_src2);
          3'b001:  w_cond = (w_src1 != w_src2);
          3'b100:  w_cond = ($signed(w_src1) < $signed(w_src2));
          3'b101:  w_cond = ($signed(w_src1) >= $signed(w_src2));
          3'b110:  w_cond = (w_src1 < w_src2);
          3'b111:  w_cond = (w_src1 >= w_src2);
          default: w_ill = 1'b1;
        endcase
        w_redir = w_cond;
      end
      7'b0010011: begin
        w_use1 = 1'b1; w_alusel = SEL_ALU; w_op1 = w_src1; w_op2 = w_imm_i; w_wr = 1'b1;
        case (w_f3)
          3'b000: w_aluop = OP_ADD;
          3'b010: w_aluop = OP_SLT;
          3'b011: w_aluop = OP_SLTU;
          3'b100: w_aluop = OP_XOR;
          3'b110: w_aluop = OP_OR;
          3'b111: w_aluop = OP_AND;
          3'b001: begin
            w_aluop = OP_SLL; w_op2 = w_shamt;
            if (w_f7 != 7'b0000000) w_ill = 1'b1;
          end
          default: begin
            w_op2 = w_shamt;
            if (w_f7 == 7'b0000000)      w_aluop = OP_SRL;
            else if (w_f7 == 7'b0100000) w_aluop = OP_SRA;
            else                         w_ill   = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        w_use1 = 1'b1; w_use2 = 1'b1;
        w_alusel = SEL_ALU; w_op1 = w_src1; w_op2 = w_src2; w_wr = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_aluop = OP_ADD;
            3'b001:  w_aluop = OP_SLL;
            3'b010:  w_aluop = OP_SLT;
            3'b011:  w_aluop = OP_SLTU;
            3'b100:  w_aluop = OP_XOR;
            3'b101:  w_aluop = OP_SRL;
            3'b110:  w_aluop = OP_OR;
            default: w_aluop = OP_AND;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_aluop = OP_SUB;
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
          w_aluop = OP_SRA;
        end else begin
          w_ill = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
    // Undecodable words issue as an inert NOP that reads nothing, so they never interlock.
    if (w_ill) begin
      w_aluop = OP_NOP; w_alusel = SEL_NOP; w_op1 = '0; w_op2 = '0; w_rd = 5'd0;
      w_wr = 1'b0; w_link = '0; w_use1 = 1'b0; w_use2 = 1'b0; w_redir = 1'b0;
    end
  end

  logic w_hazard, w_accept;
  assign w_hazard   = (w_use1 & w_pend1) | (w_use2 & w_pend2);
  assign if_ready_o = ~flush_i & ((r_state == S_DROP) |
                      ((r_state == S_RUN) & ~w_hazard & (~ex_valid_o | ex_ready_i)));
  assign w_accept   = if_valid_i & if_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      ex_valid_o  <= 1'b0;
      ex_aluop_o  <= '0;
      ex_alusel_o <= '0;
      ex_op1_o    <= '0;
      ex_op2_o    <= '0;
      ex_rd_o     <= '0;
      ex_wreg_o   <= 1'b0;
      ex_link_o   <= '0;
      br_taken_o  <= 1'b0;
      br_target_o <= '0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      r_state    <= S_RUN;
      ex_valid_o <= 1'b0;
      br_taken_o <= 1'b0;
      illegal_o  <= 1'b0;
    end else begin
      br_taken_o <= 1'b0;
      illegal_o  <= 1'b0;
      if (ex_ready_i) ex_valid_o <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            ex_valid_o  <= 1'b1;
            ex_aluop_o  <= w_aluop;
            ex_alusel_o <= w_alusel;
            ex_op1_o    <= w_op1;
            ex_op2_o    <= w_op2;
            ex_rd_o     <= w_rd;
            ex_wreg_o   <= w_wr & (w_rd != 5'd0);
            ex_link_o   <= w_link;
            br_taken_o  <= w_redir;
            illegal_o   <= w_ill;
            if (w_redir) begin
              br_target_o <= w_target;
              r_state     <= S_DROP;
            end
          end else if (if_valid_i && w_hazard) begin
            r_state <= S_STALL;
          end
        end
        S_STALL: if (!w_hazard || !if_valid_i) r_state <= S_RUN;
        S_DROP:  if (w_accept) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a mnemonic-level model checked every cycle plus literal spot checks.
module tb_rv_decode_stage;
  localparam logic [7:0] A_NOP = 8'h00, A_ADD = 8'h01, A_SUB = 8'h02, A_SLL = 8'h03, A_SLT = 8'h04,
                         A_SLTU = 8'h05, A_XOR = 8'h06, A_SRL = 8'h07, A_SRA = 8'h08, A_OR = 8'h09,
                         A_AND = 8'h0A;
  localparam logic [2:0] K_NOP = 3'd0, K_ALU = 3'd1, K_JUMP = 3'd2, K_BR = 3'd3;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, if_valid = 1'b0, ex_ready = 1'b1;
  logic [31:0] if_pc = 32'h0, if_inst = 32'h00000013;
  logic [1:0]  fwd_we = 2'b00, fwd_pend = 2'b00;
  logic [9:0]  fwd_rd = 10'h0;
  logic [63:0] fwd_data = 64'h0;
  logic [31:0] regs [32];
  logic [31:0] rf_rdata1, rf_rdata2;

  logic        if_ready_o, ex_valid_o, ex_wreg_o, br_taken_o, illegal_o;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o, ex_rd_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_op1_o, ex_op2_o, ex_link_o, br_target_o;

  assign rf_rdata1 = regs[if_inst[19:15]];
  assign rf_rdata2 = regs[if_inst[24:20]];

  rv_decode_stage #(.XLEN(32), .NFWD(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready_o),
    .if_pc_i(if_pc), .if_inst_i(if_inst), .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2), .fwd_we_i(fwd_we), .fwd_pend_i(fwd_pend),
    .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready),
    .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
    .ex_rd_o(ex_rd_o), .ex_wreg_o(ex_wreg_o), .ex_link_o(ex_link_o), .br_taken_o(br_taken_o),
    .br_target_o(br_target_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wreg;
    logic [31:0] link;
    logic        redir;
    logic [31:0] tgt;
    logic        ill;
    logic        hz;
  } exp_t;

  // Source value as seen by decode: x0, then port 0, then port 1, then the register file.
  function automatic void fwd_src(input logic [4:0] r, output logic [31:0] v, output logic p);
    v = regs[r];
    p = 1'b0;
    if (r == 5'd0) v = 32'h0;
    else if (fwd_we[0] && fwd_rd[4:0] == r) begin v = fwd_data[31:0];  p = fwd_pend[0]; end
    else if (fwd_we[1] && fwd_rd[9:5] == r) begin v = fwd_data[63:32]; p = fwd_pend[1]; end
  endfunction

  function automatic exp_t mdec(input logic [31:0] in, input logic [31:0] pc);
    exp_t e;
    logic [31:0] a, b, ii, ib, ij;
    logic pa, pb, r1, r2;
    e = '0;
    r1 = 1'b0;
    r2 = 1'b0;
    fwd_src(in[19:15], a, pa);
    fwd_src(in[24:20], b, pb);
    ii = 32'($signed(in[31:20]));
    ib = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
    ij = 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
    case (in[6:0])
      7'h37: begin e.aluop = A_ADD; e.sel = K_ALU; e.op2 = {in[31:12], 12'h0}; e.rd = in[11:7]; e.wreg = 1'b1; end
      7'h17: begin e.aluop = A_ADD; e.sel = K_ALU; e.op1 = pc; e.op2 = {in[31:12], 12'h0}; e.rd = in[11:7]; e.wreg = 1'b1; end
      7'h6F: begin
        e.aluop = A_ADD; e.sel = K_JUMP; e.op1 = pc; e.op2 = 32'd4; e.rd = in[11:7]; e.wreg = 1'b1;
        e.link = pc + 32'd4; e.redir = 1'b1; e.tgt = pc + ij;
      end
      7'h67: begin
        if (in[14:12] != 3'd0) e.ill = 1'b1;
        r1 = 1'b1;
        e.aluop = A_ADD; e.sel = K_JUMP; e.op1 = pc; e.op2 = 32'd4; e.rd = in[11:7]; e.wreg = 1'b1;
        e.link = pc + 32'd4; e.redir = 1'b1; e.tgt = (a + ii) & 32'hFFFF_FFFE;
      end
      7'h63: begin
        r1 = 1'b1; r2 = 1'b1;
        e.aluop = A_NOP; e.sel = K_BR; e.op1 = a; e.op2 = b; e.tgt = pc + ib;
        case (in[14:12])
          3'd0: e.redir = (a == b);
          3'd1: e.redir = (a != b);
          3'd4: e.redir = ($signed(a) < $signed(b));
          3'd5: e.redir = !($signed(a) < $signed(b));
          3'd6: e.redir = (a < b);
          3'd7: e.redir = !(a < b);
          default: e.ill = 1'b1;
        endcase
      end
      7'h13: begin
        r1 = 1'b1; e.sel = K_ALU; e.op1 = a; e.op2 = ii; e.rd = in[11:7]; e.wreg = 1'b1;
        case (in[14:12])
          3'd0: e.aluop = A_ADD;
          3'd2: e.aluop = A_SLT;
          3'd3: e.aluop = A_SLTU;
          3'd4: e.aluop = A_XOR;
          3'd6: e.aluop = A_OR;
          3'd7: e.aluop = A_AND;
          3'd1: begin e.aluop = A_SLL; e.op2 = {27'h0, in[24:20]}; if (in[31:25] != 7'h00) e.ill = 1'b1; end
          default: begin
            e.op2 = {27'h0, in[24:20]};
            if (in[31:25] == 7'h00) e.aluop = A_SRL;
            else if (in[31:25] == 7'h20) e.aluop = A_SRA;
            else e.ill = 1'b1;
          end
        endcase
      end
      7'h33: begin
        r1 = 1'b1; r2 = 1'b1; e.sel = K_ALU; e.op1 = a; e.op2 = b; e.rd = in[11:7]; e.wreg = 1'b1;
        if (in[31:25] == 7'h00) begin
          case (in[14:12])
            3'd0: e.aluop = A_ADD;  3'd1: e.aluop = A_SLL;
            3'd2: e.aluop = A_SLT;  3'd3: e.aluop = A_SLTU;
            3'd4: e.aluop = A_XOR;  3'd5: e.aluop = A_SRL;
            3'd6: e.aluop = A_OR;   default: e.aluop = A_AND;
          endcase
        end else if (in[31:25] == 7'h20 && in[14:12] == 3'd0) e.aluop = A_SUB;
        else if (in[31:25] == 7'h20 && in[14:12] == 3'd5) e.aluop = A_SRA;
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e = '0;
      e.ill = 1'b1;
    end else begin
      e.hz = (r1 && pa) || (r2 && pb);
      if (e.rd == 5'd0) e.wreg = 1'b0;
    end
    return e;
  endfunction

  // Model of what the stage holds: issued entry, pulses, and whether it is stalling or dropping.
  exp_t        m_ex;
  logic        m_valid, m_br, m_ill, m_drop, m_stall;
  logic [31:0] m_tgt;
  bit          live = 1'b0;

  always @(negedge clk) begin
    exp_t d;
    logic rdy, acc;
    d = mdec(if_inst, if_pc);
    rdy = !flush && (m_drop || (!m_stall && !d.hz && (!m_valid || ex_ready)));
    if (live && !rst) begin
      chk("ex_valid", 32'(ex_valid_o), 32'(m_valid));
      chk("br_taken", 32'(br_taken_o), 32'(m_br));
      chk("illegal", 32'(illegal_o), 32'(m_ill));
      chk("if_ready", 32'(if_ready_o), 32'(rdy));
      chk("rf_raddr", 32'({rf_raddr2_o, rf_raddr1_o}), 32'({if_inst[24:20], if_inst[19:15]}));
      if (m_valid) begin
        chk("ex_aluop", 32'(ex_aluop_o), 32'(m_ex.aluop));
        chk("ex_alusel", 32'(ex_alusel_o), 32'(m_ex.sel));
        chk("ex_op1", ex_op1_o, m_ex.op1);
        chk("ex_op2", ex_op2_o, m_ex.op2);
        chk("ex_rd", 32'(ex_rd_o), 32'(m_ex.rd));
        chk("ex_wreg", 32'(ex_wreg_o), 32'(m_ex.wreg));
        chk("ex_link", ex_link_o, m_ex.link);
      end
      if (m_br) chk("br_target", br_target_o, m_tgt);
    end
    acc = if_valid && rdy;
    if (rst) begin
      m_ex = '0; m_valid = 1'b0; m_br = 1'b0; m_ill = 1'b0; m_drop = 1'b0; m_stall = 1'b0;
      m_tgt = 32'h0; live = 1'b1;
    end else if (flush) begin
      m_valid = 1'b0; m_br = 1'b0; m_ill = 1'b0; m_drop = 1'b0; m_stall = 1'b0;
    end else begin
      m_br = 1'b0;
      m_ill = 1'b0;
      if (ex_ready) m_valid = 1'b0;
      if (m_drop) begin
        if (acc) m_drop = 1'b0;
      end else if (m_stall) begin
        if (!d.hz || !if_valid) m_stall = 1'b0;
      end else if (acc) begin
        m_ex = d;
        m_valid = 1'b1;
        m_br = d.redir;
        m_ill = d.ill;
        if (d.redir) begin m_tgt = d.tgt; m_drop = 1'b1; end
      end else if (if_valid && d.hz) begin
        m_stall = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    bit got;
    got = 1'b0;
    if_pc = pc;
    if_inst = inst;
    if_valid = 1'b1;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = if_ready_o;
      @(posedge clk);
      #1;
    end
    if_valid = 1'b0;
    chk("accept_within_bound", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    idle(2);
    rst = 1'b0;
    chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_br_taken", 32'(br_taken_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_wreg", 32'(ex_wreg_o), 32'd0);
    chk("rst_op1", ex_op1_o, 32'h0);
    chk("rst_op2", ex_op2_o, 32'h0);
    chk("rst_target", br_target_o, 32'h0);
    chk("rst_if_ready", 32'(if_ready_o), 32'd1);
    idle(1);

    // addi x1,x0,-5
    send(32'h0, 32'hFFB00093);
    chk("t1_valid", 32'(ex_valid_o), 32'd1);
    chk("t1_op1", ex_op1_o, 32'h0);
    chk("t1_op2", ex_op2_o, 32'hFFFF_FFFB);
    chk("t1_rd", 32'(ex_rd_o), 32'd1);
    chk("t1_wreg", 32'(ex_wreg_o), 32'd1);
    chk("t1_aluop", 32'(ex_aluop_o), 32'(A_ADD));

    // add x3,x1,x2 with both ports writing x1: port 0 wins
    regs[2] = 32'h20;
    fwd_we = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_data = {32'd9, 32'd7};
    send(32'h4, 32'h002081B3);
    chk("t2_op1_port0", ex_op1_o, 32'd7);
    chk("t2_op2_rf", ex_op2_o, 32'h20);
    // add x3,x0,x2 with port 0 targeting x0: x0 still reads zero
    fwd_we = 2'b01; fwd_rd = 10'h0; fwd_data = 64'h55;
    send(32'h8, 32'h002001B3);
    chk("t2_x0_op1", ex_op1_o, 32'h0);
    fwd_we = 2'b00;

    // add x3,x2,x2 behind a pending load to x2
    fwd_we = 2'b01; fwd_pend = 2'b01; fwd_rd = {5'd0, 5'd2}; fwd_data = 64'h77;
    if_pc = 32'hC; if_inst = 32'h002101B3; if_valid = 1'b1;
    @(negedge clk);
    chk("t3_stall_ready", 32'(if_ready_o), 32'd0);
    @(posedge clk); #1;
    fwd_pend = 2'b00;
    send(32'hC, 32'h002101B3);
    chk("t3_op1", ex_op1_o, 32'h77);
    chk("t3_op2", ex_op2_o, 32'h77);
    fwd_we = 2'b00;

    // signed vs unsigned branch on x1=-1, x2=1
    regs[1] = 32'hFFFF_FFFF; regs[2] = 32'h1;
    send(32'h100, 32'h0020C863);
    chk("t4_blt_taken", 32'(br_taken_o), 32'd1);
    chk("t4_blt_target", br_target_o, 32'h110);
    chk("t4_blt_wreg", 32'(ex_wreg_o), 32'd0);
    send(32'h104, 32'hFFB00093);
    chk("t4_drop_valid", 32'(ex_valid_o), 32'd0);
    chk("t4_drop_br", 32'(br_taken_o), 32'd0);
    send(32'h200, 32'h0020E863);
    chk("t4_bltu_not_taken", 32'(br_taken_o), 32'd0);
    chk("t4_bltu_valid", 32'(ex_valid_o), 32'd1);

    // jalr x1,4(x5)
    regs[5] = 32'h203;
    send(32'h300, 32'h004280E7);
    chk("t5_jalr_taken", 32'(br_taken_o), 32'd1);
    chk("t5_jalr_target", br_target_o, 32'h206);
    chk("t5_jalr_link", ex_link_o, 32'h304);
    send(32'h304, 32'hFFB00093);
    chk("t5_drop_valid", 32'(ex_valid_o), 32'd0);

    // jal x1,+8 then its dropped shadow beat
    send(32'h500, 32'h008000EF);
    chk("jal_target", br_target_o, 32'h508);
    send(32'h504, 32'h002081B3);

    // a load opcode is not decoded here
    send(32'h600, 32'h00000003);
    chk("ill_pulse", 32'(illegal_o), 32'd1);
    chk("ill_wreg", 32'(ex_wreg_o), 32'd0);
    idle(1);
    chk("ill_one_cycle", 32'(illegal_o), 32'd0);

    // sub, srai, lui, auipc: model-checked
    send(32'h610, 32'h40208233);
    send(32'h614, 32'h4030D313);
    send(32'h618, 32'h123453B7);
    send(32'h400, 32'h00001417);
    idle(2);

    // backpressure, a held hazard, then a flush out of the stall
    ex_ready = 1'b0;
    send(32'h700, 32'hFFB00093);
    fwd_we = 2'b01; fwd_pend = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_data = 64'h0;
    if_pc = 32'h704; if_inst = 32'h002081B3; if_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_hold_ready", 32'(if_ready_o), 32'd0);
      chk("t6_hold_valid", 32'(ex_valid_o), 32'd1);
      chk("t6_hold_op2", ex_op2_o, 32'hFFFF_FFFB);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; fwd_we = 2'b00; fwd_pend = 2'b00; ex_ready = 1'b1;
    chk("t6_flush_valid", 32'(ex_valid_o), 32'd0);
    @(negedge clk);
    chk("t6_flush_run_ready", 32'(if_ready_o), 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
